// File: rtl/uart_tx_serializer.sv
// UART transmit serializer: builds start/data/parity/stop frames, one-deep holding register.
// Optional line-break generation when UART_TX_BREAK_EN is defined (adds the break_req input).
module uart_tx_serializer #(
  parameter int DATA_W_MAX = 8
) (
  input  logic                  baud_out,
  input  logic                  rst,
  input  logic                  send,
  input  logic [DATA_W_MAX-1:0] data_in,
  input  logic [3:0]            data_len,
  input  logic [1:0]            parity_type,
  input  logic                  stop_bits,
`ifdef UART_TX_BREAK_EN
  input  logic                  break_req,
`endif
  output logic                  data_out,
  output logic                  p_parity_out,
  output logic                  tx_active,
  output logic                  tx_done,
  output logic                  ready,
  output logic                  overrun
);
  localparam int LEN_W = 5;
  localparam logic [LEN_W-1:0] LEN_MIN = LEN_W'(5);
  localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(DATA_W_MAX);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP1, S_STOP2} state_t;

  typedef struct packed {
    logic [DATA_W_MAX-1:0] data;
    logic [LEN_W-1:0]      len;
    logic                  par_en;
    logic                  par_bit;
    logic                  stop2;
  } frame_t;

  state_t           state_q, state_d;
  frame_t           cur_q, cur_d, hold_q, hold_d, new_frame, fr;
  logic             hold_valid_q, hold_valid_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic             send_q, send_d;
  logic             data_out_q, data_out_d;
  logic             p_parity_q, p_parity_d;
  logic             tx_active_q, tx_active_d;
  logic             tx_done_q, tx_done_d;
  logic             ready_q, ready_d;
  logic             overrun_q, overrun_d;

  logic                  brk, req, accept;
  logic                  launch_new, launch_hold, to_idle, frame_end;
  logic [LEN_W-1:0]      cap_len;
  logic [DATA_W_MAX-1:0] len_mask;
  logic                  data_par;

`ifdef UART_TX_BREAK_EN
  assign brk = break_req;
`else
  assign brk = 1'b0;
`endif

  assign req    = send_q & ~send;
  assign accept = req & ready_q;

  always_comb begin
    if ({1'b0, data_len} < LEN_MIN)
      cap_len = LEN_MIN;
    else if ({1'b0, data_len} > LEN_MAX)
      cap_len = LEN_MAX;
    else
      cap_len = {1'b0, data_len};
  end

  for (genvar gi = 0; gi < DATA_W_MAX; gi++) begin : g_mask
    assign len_mask[gi] = (LEN_W'(gi) < cap_len);
  end

  // Parity covers only the bits that will actually be sent.
  assign data_par = ^(data_in & len_mask);

  always_comb begin
    new_frame.data    = data_in & len_mask;
    new_frame.len     = cap_len;
    new_frame.par_en  = (parity_type == 2'b01) || (parity_type == 2'b10);
    new_frame.par_bit = (parity_type == 2'b01) ? ~data_par :
                        (parity_type == 2'b10) ?  data_par : 1'b0;
    new_frame.stop2   = stop_bits;
  end

  always_comb begin
    state_d      = state_q;
    cur_d        = cur_q;
    hold_d       = hold_q;
    hold_valid_d = hold_valid_q;
    cnt_d        = cnt_q;
    send_d       = send;
    data_out_d   = data_out_q;
    p_parity_d   = p_parity_q;
    tx_active_d  = tx_active_q;
    tx_done_d    = 1'b0;
    overrun_d    = req & ~ready_q;
    launch_new   = 1'b0;
    launch_hold  = 1'b0;
    to_idle      = 1'b0;
    frame_end    = 1'b0;
    fr           = new_frame;

    case (state_q)
      S_IDLE: begin
        if (hold_valid_q && !brk)
          launch_hold = 1'b1;
        else if (accept && !brk)
          launch_new = 1'b1;
        else
          to_idle = 1'b1;
      end
      S_START: begin
        state_d    = S_DATA;
        data_out_d = cur_q.data[0];
        cur_d.data = cur_q.data >> 1;
        cnt_d      = cur_q.len - LEN_W'(1);
      end
      S_DATA: begin
        if (cnt_q != '0) begin
          data_out_d = cur_q.data[0];
          cur_d.data = cur_q.data >> 1;
          cnt_d      = cnt_q - LEN_W'(1);
        end else if (cur_q.par_en) begin
          state_d    = S_PARITY;
          data_out_d = cur_q.par_bit;
        end else begin
          state_d    = S_STOP1;
          data_out_d = 1'b1;
        end
      end
      S_PARITY: begin
        state_d    = S_STOP1;
        data_out_d = 1'b1;
      end
      S_STOP1: begin
        if (cur_q.stop2) begin
          state_d    = S_STOP2;
          data_out_d = 1'b1;
        end else begin
          frame_end = 1'b1;
        end
      end
      S_STOP2: frame_end = 1'b1;
      default: to_idle = 1'b1;
    endcase

    // A break pending at frame end wins over a queued frame.
    if (frame_end) begin
      tx_done_d = 1'b1;
      if (hold_valid_q && !brk)
        launch_hold = 1'b1;
      else
        to_idle = 1'b1;
    end

    if (launch_hold)
      fr = hold_q;
    if (launch_new || launch_hold) begin
      state_d     = S_START;
      cur_d       = fr;
      data_out_d  = 1'b0;
      tx_active_d = 1'b1;
      p_parity_d  = fr.par_bit;
    end
    if (to_idle) begin
      state_d     = S_IDLE;
      data_out_d  = ~brk;
      tx_active_d = brk;
      p_parity_d  = 1'b0;
    end

    if (launch_hold)
      hold_valid_d = 1'b0;
    if (accept && !launch_new) begin
      hold_d       = new_frame;
      hold_valid_d = 1'b1;
    end
    ready_d = ~hold_valid_d;
  end

  always_ff @(posedge baud_out) begin
    if (rst) begin
      state_q      <= S_IDLE;
      cur_q        <= '0;
      hold_q       <= '0;
      hold_valid_q <= 1'b0;
      cnt_q        <= '0;
      send_q       <= 1'b1;
      data_out_q   <= 1'b1;
      p_parity_q   <= 1'b0;
      tx_active_q  <= 1'b0;
      tx_done_q    <= 1'b0;
      ready_q      <= 1'b1;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      cur_q        <= cur_d;
      hold_q       <= hold_d;
      hold_valid_q <= hold_valid_d;
      cnt_q        <= cnt_d;
      send_q       <= send_d;
      data_out_q   <= data_out_d;
      p_parity_q   <= p_parity_d;
      tx_active_q  <= tx_active_d;
      tx_done_q    <= tx_done_d;
      ready_q      <= ready_d;
      overrun_q    <= overrun_d;
    end
  end

  assign data_out     = data_out_q;
  assign p_parity_out = p_parity_q;
  assign tx_active    = tx_active_q;
  assign tx_done      = tx_done_q;
  assign ready        = ready_q;
  assign overrun      = overrun_q;

endmodule
